pe_scan_seq: RTL and testbench

Parametrised sequential priority encoder (bit-scan unit), the next generation of the team's combinational 8-to-3 priority encoder.
- Captures a WIDTH-bit request vector through a valid/ready handshake.
- Emits the index of every set bit, one per output beat, highest index first.
- Flags the final beat.
- Used wherever a request vector must be serviced completely rather than only its top-priority bit.

---
 rtl/pe_scan_seq_if.sv | 39 +++
 rtl/pe_scan_seq.sv | 141 ++++++++++++++
 tb/tb_pe_scan_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pe_scan_seq_if.sv
// Handshake bundle for pe_scan_seq: request vector in, one index beat out.
// The slave modport is the scan unit; the master modport is whoever feeds
// vectors and consumes beats.
interface pe_scan_seq_if #(
  parameter int WIDTH = 8
);
  localparam int IDXW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             out_none;

  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last,
    output out_none
  );

  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  out_none
  );
endinterface

// File: rtl/pe_scan_seq.sv
// pe_scan_seq: sequential priority encoder / bit-scan unit.
// Captures a WIDTH-bit request vector and emits the index of every set bit,
// highest index first, one beat per output handshake; the final beat is
// flagged with out_last and an all-zero vector yields one beat with out_none.
// All outputs come straight from flops: the next values are precomputed from
// the next-state pending vector, so no input reaches an output in the same
// cycle.
// Optional macro PE_FLUSH_EN adds a flush input that abandons the current
// vector (priority over capture and output handshake).
module pe_scan_seq #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
`ifdef PE_FLUSH_EN
  input logic flush,
`endif
  pe_scan_seq_if.slave bus
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_VEC = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VEC  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Position of the highest set bit; 0 for an all-zero vector.
  function automatic logic [IDXW-1:0] highest_set(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] r;
    r = {IDXW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        r = i[IDXW-1:0];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // True when the vector has zero or one bit set (clearing lowest set bit leaves nothing).
  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    return ((v & (v - ONE_VEC)) == ZERO_VEC);
  endfunction

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] pending_q,   pending_d;
  logic             none_q,      none_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [IDXW-1:0]  out_idx_q,   out_idx_d;
  logic             out_last_q,  out_last_d;
  logic             out_none_q,  out_none_d;

  // Next-state logic plus precomputation of the next registered outputs.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = none_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          pending_d = bus.in_vec;
          none_d    = (bus.in_vec == ZERO_VEC);
          state_d   = ST_SCAN;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (bus.out_ready) begin
          // out_idx_q always names the highest pending bit (or 0 when empty).
          pending_d = pending_q & ~(ONE_VEC << out_idx_q);
          if (out_last_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SCAN;
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = ZERO_VEC;
        none_d    = 1'b0;
      end
    endcase

`ifdef PE_FLUSH_EN
    if (flush) begin
      state_d   = ST_IDLE;
      pending_d = ZERO_VEC;
      none_d    = 1'b0;
    end else begin
      state_d   = state_d;
    end
`endif

    // pending_d is always zero when heading to IDLE, so out_idx_d is 0 there.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_SCAN);
    out_idx_d   = highest_set(pending_d);
    out_last_d  = (state_d == ST_SCAN) && at_most_one(pending_d);
    out_none_d  = (state_d == ST_SCAN) && none_d;
  end

  // FSM state, pending vector and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= ZERO_VEC;
      none_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_idx_q   <= {IDXW{1'b0}};
      out_last_q  <= 1'b0;
      out_none_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      none_q      <= none_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_none_q  <= out_none_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_none  = out_none_q;

endmodule

// File: tb/tb_pe_scan_seq.sv
// Self-checking bench for pe_scan_seq: an 8-bit and a 5-bit instance, directed
// cases followed by random vectors with random backpressure. Expected beats
// come from a list of set-bit positions built highest-first from each vector.
module tb_pe_scan_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pe_scan_seq_if #(.WIDTH(8)) if8 ();
  pe_scan_seq_if #(.WIDTH(5)) if5 ();

`ifdef PE_FLUSH_EN
  logic flush;
  logic flush5;
`endif

  pe_scan_seq #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef PE_FLUSH_EN
    .flush (flush),
`endif
    .bus   (if8.slave)
  );

  pe_scan_seq #(.WIDTH(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef PE_FLUSH_EN
    .flush (flush5),
`endif
    .bus   (if5.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit sel, input logic iv, input logic [7:0] vec, input logic ordy);
    if (sel) begin
      if5.in_valid  = iv;
      if5.in_vec    = vec[4:0];
      if5.out_ready = ordy;
    end else begin
      if8.in_valid  = iv;
      if8.in_vec    = vec;
      if8.out_ready = ordy;
    end
  endtask

  task automatic samp(input bit sel, output logic ov, output logic ir,
                      output logic [31:0] idx, output logic last, output logic none);
    if (sel) begin
      ov = if5.out_valid; ir = if5.in_ready; idx = 32'(if5.out_idx);
      last = if5.out_last; none = if5.out_none;
    end else begin
      ov = if8.out_valid; ir = if8.in_ready; idx = 32'(if8.out_idx);
      last = if8.out_last; none = if8.out_none;
    end
  endtask

  task automatic check_idle(input bit sel, input string tag);
    logic ov, ir, last, none;
    logic [31:0] idx;
    samp(sel, ov, ir, idx, last, none);
    chk({tag, "_out_valid"}, 32'(ov), 32'd0);
    chk({tag, "_in_ready"},  32'(ir), 32'd1);
  endtask

  task automatic check_beat(input bit sel, input string tag, input int exp_idx,
                            input bit exp_last, input bit exp_none);
    logic ov, ir, last, none;
    logic [31:0] idx;
    samp(sel, ov, ir, idx, last, none);
    chk({tag, "_out_valid"}, 32'(ov),   32'd1);
    chk({tag, "_in_ready"},  32'(ir),   32'd0);
    chk({tag, "_out_idx"},   idx,       32'(exp_idx));
    chk({tag, "_out_last"},  32'(last), 32'(exp_last));
    chk({tag, "_out_none"},  32'(none), 32'(exp_none));
  endtask

  // Present one vector on the chosen instance and walk every expected beat.
  task automatic run_vec(input bit sel, input logic [7:0] vec, input int first_stall,
                         input int rand_max, input string tag);
    int w;
    int q[$];
    bit none;
    int stall;
    w = sel ? 5 : 8;
    for (int i = w - 1; i >= 0; i--) begin
      if (vec[i]) q.push_back(i);
    end
    none = (q.size() == 0);
    if (none) q.push_back(0);

    check_idle(sel, {tag, "_pre"});
    drv(sel, 1'b1, vec, 1'b0);
    @(negedge clk);
    for (int k = 0; k < q.size(); k++) begin
      stall = (k == 0) ? first_stall : int'($urandom_range(0, rand_max));
      for (int s = 0; s < stall; s++) begin
        drv(sel, 1'b1, 8'($urandom), 1'b0);
        check_beat(sel, {tag, "_stall"}, q[k], k == q.size() - 1, none);
        @(negedge clk);
      end
      drv(sel, 1'($urandom), 8'($urandom), 1'b1);
      check_beat(sel, {tag, "_beat"}, q[k], k == q.size() - 1, none);
      @(negedge clk);
    end
    drv(sel, 1'b0, 8'h00, 1'b0);
    check_idle(sel, {tag, "_post"});
  endtask

  initial begin
    logic ov, ir, last, none;
    logic [31:0] idx;
    logic [7:0] v;
    bit sel;

    rst_n = 1'b0;
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    drv(1'b1, 1'b0, 8'h00, 1'b0);
`ifdef PE_FLUSH_EN
    flush  = 1'b0;
    flush5 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      samp(s[0], ov, ir, idx, last, none);
      chk("rst_out_valid", 32'(ov),   32'd0);
      chk("rst_in_ready",  32'(ir),   32'd1);
      chk("rst_out_idx",   idx,       32'd0);
      chk("rst_out_last",  32'(last), 32'd0);
      chk("rst_out_none",  32'(none), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Sparse vector, zero vector, full vector with initial backpressure.
    run_vec(1'b0, 8'b1010_0010, 0, 0, "t1");
    run_vec(1'b0, 8'h00,        0, 0, "t2");
    run_vec(1'b0, 8'hFF,        3, 0, "t3");

    // Non-power-of-two width.
    run_vec(1'b1, 8'h11, 0, 0, "t4a");
    run_vec(1'b1, 8'h01, 0, 0, "t4b");
    run_vec(1'b1, 8'h1F, 1, 2, "t4full");
    run_vec(1'b1, 8'h00, 0, 0, "t4zero");

    // Reset in the middle of a scan.
    drv(1'b0, 1'b1, 8'hC3, 1'b0);
    @(negedge clk);
    drv(1'b0, 1'b0, 8'h00, 1'b1);
    check_beat(1'b0, "t5_first", 7, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    samp(1'b0, ov, ir, idx, last, none);
    chk("t5_rst_out_valid", 32'(ov), 32'd0);
    chk("t5_rst_in_ready",  32'(ir), 32'd1);
    chk("t5_rst_out_idx",   idx,     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    run_vec(1'b0, 8'h10, 0, 0, "t5_next");

`ifdef PE_FLUSH_EN
    // Flush during the second beat discards the rest of the vector.
    drv(1'b0, 1'b1, 8'hF0, 1'b0);
    @(negedge clk);
    drv(1'b0, 1'b0, 8'h00, 1'b1);
    check_beat(1'b0, "t6_b7", 7, 1'b0, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    check_beat(1'b0, "t6_b6", 6, 1'b0, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    check_idle(1'b0, "t6_flushed");
    @(negedge clk);
    check_idle(1'b0, "t6_quiet");
    run_vec(1'b0, 8'h02, 0, 0, "t6_next");
    // Flush in IDLE blocks capture.
    drv(1'b0, 1'b1, 8'h55, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    check_idle(1'b0, "t6_idle_flush");
    @(negedge clk);
`endif

    // Random vectors with random backpressure on both widths.
    for (int it = 0; it < 40; it++) begin
      sel = 1'($urandom);
      v   = 8'($urandom);
      if (it % 10 == 3) v = 8'h00;
      if (it % 10 == 7) v = 8'hFF;
      if (sel) v = v & 8'h1F;
      run_vec(sel, v, int'($urandom_range(0, 2)), 3, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
